ahb_bridge_arbiter: RTL and testbench

Multi-master AHB arbiter that shares the single AHB-to-APB bridge (Bridge_Top) slave port between NUM_MASTERS requesters. Round-robin grant with per-owner hold limit. Address/control mux follows the address-phase owner; write-data mux follows the data-phase owner, preserving AHB pipelining. Sits directly in front of Bridge_Top; the bridge's response returns to all masters.

---
 rtl/ahb_bridge_arbiter_pkg.sv | 20 ++
 rtl/ahb_bridge_arbiter_rr_arbiter.sv | 33 +++
 rtl/ahb_bridge_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ahb_bridge_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_arbiter_pkg.sv
// Shared AHB encodings and arbiter state type for the bridge arbiter.
package ahb_bridge_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [1:0] HRESP_RETRY   = 2'b10;
   localparam logic [1:0] HRESP_SPLIT   = 2'b11;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_OWN   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ahb_bridge_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
   import ahb_bridge_pkg::*;
#(
   parameter int unsigned N     = 3,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic             valid
);

   // Scan N positions starting at ptr; the first set request wins.
   always_comb begin
      int unsigned      idx;
      logic [PTR_W-1:0] sel;
      gnt   = '0;
      valid = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = PTR_W'(idx);
         if (!valid && req[sel]) begin
            gnt[sel] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_bridge_arbiter.sv
// Multi-master arbiter sharing one AHB-to-APB bridge slave port.
// Address path follows the address-phase owner, write data follows the
// data-phase owner so a handover overlaps the old data and new address phases.
module ahb_bridge_arbiter
   import ahb_bridge_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 3,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MAX_HOLD    = 16
) (
   input  logic                          Hclk,
   input  logic                          Hreset,
   input  logic [NUM_MASTERS-1:0]        Hbusreq,
   output logic [NUM_MASTERS-1:0]        Hgrant,
   input  logic [NUM_MASTERS*ADDR_W-1:0] M_Haddr,
   input  logic [NUM_MASTERS*2-1:0]      M_Htrans,
   input  logic [NUM_MASTERS-1:0]        M_Hwrite,
   input  logic [NUM_MASTERS*DATA_W-1:0] M_Hwdata,
   output logic [ADDR_W-1:0]             Haddr,
   output logic [1:0]                    Htrans,
   output logic                          Hwrite,
   output logic [DATA_W-1:0]             Hwdata,
   output logic                          Hreadyin,
   input  logic                          Hreadyout,
   input  logic [1:0]                    Hresp,
   input  logic [DATA_W-1:0]             Hrdata,
   output logic                          M_Hready,
   output logic [1:0]                    M_Hresp,
   output logic [DATA_W-1:0]             M_Hrdata,
   output logic [NUM_MASTERS-1:0]        addr_owner
);

   localparam int unsigned PTR_W = $clog2(NUM_MASTERS);
   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

   arb_state_t             state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [CNT_W-1:0]       hold_cnt;
   logic [NUM_MASTERS-1:0] data_owner;
   logic                   data_valid;

   logic [PTR_W-1:0]       owner_idx;
   logic [ADDR_W-1:0]      owner_addr;
   logic [1:0]             owner_trans;
   logic                   owner_write;
   logic                   owner_req;
   logic [DATA_W-1:0]      wdata_mux;
   logic [PTR_W-1:0]       next_ptr;
   logic [PTR_W-1:0]       arb_ptr;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_valid;
   logic                   rearb;

   // Select the address-phase owner's request and control slices.
   always_comb begin
      owner_idx   = '0;
      owner_addr  = '0;
      owner_trans = HTRANS_IDLE;
      owner_write = 1'b0;
      owner_req   = 1'b0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (addr_owner[i]) begin
            owner_idx   = PTR_W'(i);
            owner_addr  = M_Haddr[i*ADDR_W +: ADDR_W];
            owner_trans = M_Htrans[i*2 +: 2];
            owner_write = M_Hwrite[i];
            owner_req   = Hbusreq[i];
         end
      end
   end

   // Select write data of the data-phase owner; zero when no data phase.
   always_comb begin
      wdata_mux = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (data_valid && data_owner[i]) wdata_mux = M_Hwdata[i*DATA_W +: DATA_W];
      end
   end

   assign next_ptr = (owner_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : owner_idx + PTR_W'(1);
   assign arb_ptr  = (state == ARB_OWN) ? next_ptr : rr_ptr;

   // Release when the owner drops its request, or when its quota is used up
   // at a point that does not split a burst.
   assign rearb = !owner_req ||
                  ((hold_cnt >= CNT_W'(MAX_HOLD)) &&
                   (owner_trans != HTRANS_SEQ) && (owner_trans != HTRANS_BUSY));

   rr_arbiter #(
      .N     (NUM_MASTERS),
      .PTR_W (PTR_W)
   ) u_rr (
      .req   (Hbusreq),
      .ptr   (arb_ptr),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   // Arbitration FSM, hold counter and data-phase tracking.
   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state      <= ARB_IDLE;
         Hgrant     <= '0;
         addr_owner <= '0;
         data_owner <= '0;
         data_valid <= 1'b0;
         rr_ptr     <= '0;
         hold_cnt   <= '0;
      end else begin
         if (Hreadyout) begin
            data_owner <= addr_owner;
            data_valid <= Htrans[1];
         end
         case (state)
            ARB_IDLE: begin
               if (pick_valid) begin
                  Hgrant <= pick_gnt;
                  state  <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (Hreadyout) begin
                  addr_owner <= Hgrant;
                  hold_cnt   <= '0;
                  state      <= ARB_OWN;
               end
            end
            ARB_OWN: begin
               if (Hreadyout) begin
                  if (owner_trans[1] && (hold_cnt < CNT_W'(MAX_HOLD)))
                     hold_cnt <= hold_cnt + CNT_W'(1);
                  if (rearb) begin
                     rr_ptr <= next_ptr;
                     if (pick_valid) begin
                        Hgrant <= pick_gnt;
                        state  <= ARB_GRANT;
                     end else begin
                        Hgrant     <= '0;
                        addr_owner <= '0;
                        state      <= ARB_IDLE;
                     end
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   assign Haddr    = owner_addr;
   assign Htrans   = owner_trans;
   assign Hwrite   = owner_write;
   assign Hwdata   = wdata_mux;
   assign Hreadyin = Hreadyout;
   assign M_Hready = Hreadyout;
   assign M_Hresp  = Hresp;
   assign M_Hrdata = Hrdata;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter (3 masters, hold limit 4).
module tb_ahb_bridge_arbiter;

   localparam int unsigned NM = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NS   = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   logic             Hclk = 1'b0;
   logic             Hreset;
   logic [NM-1:0]    Hbusreq;
   logic [NM-1:0]    Hgrant;
   logic [NM*AW-1:0] M_Haddr;
   logic [NM*2-1:0]  M_Htrans;
   logic [NM-1:0]    M_Hwrite;
   logic [NM*DW-1:0] M_Hwdata;
   logic [AW-1:0]    Haddr;
   logic [1:0]       Htrans;
   logic             Hwrite;
   logic [DW-1:0]    Hwdata;
   logic             Hreadyin;
   logic             Hreadyout;
   logic [1:0]       Hresp;
   logic [DW-1:0]    Hrdata;
   logic             M_Hready;
   logic [1:0]       M_Hresp;
   logic [DW-1:0]    M_Hrdata;
   logic [NM-1:0]    addr_owner;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 Hclk = ~Hclk;

   ahb_bridge_arbiter #(
      .NUM_MASTERS (NM),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .MAX_HOLD    (4)
   ) dut (
      .Hclk       (Hclk),
      .Hreset     (Hreset),
      .Hbusreq    (Hbusreq),
      .Hgrant     (Hgrant),
      .M_Haddr    (M_Haddr),
      .M_Htrans   (M_Htrans),
      .M_Hwrite   (M_Hwrite),
      .M_Hwdata   (M_Hwdata),
      .Haddr      (Haddr),
      .Htrans     (Htrans),
      .Hwrite     (Hwrite),
      .Hwdata     (Hwdata),
      .Hreadyin   (Hreadyin),
      .Hreadyout  (Hreadyout),
      .Hresp      (Hresp),
      .Hrdata     (Hrdata),
      .M_Hready   (M_Hready),
      .M_Hresp    (M_Hresp),
      .M_Hrdata   (M_Hrdata),
      .addr_owner (addr_owner)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic set_tr(input int idx, input logic [1:0] tr);
      M_Htrans[idx*2 +: 2] = tr;
   endtask

   task automatic do_reset();
      Hreset    = 1'b1;
      Hbusreq   = '0;
      M_Htrans  = '0;
      Hreadyout = 1'b1;
      Hresp     = 2'b00;
      tick();
      tick();
      Hreset = 1'b0;
   endtask

   logic [1:0]    burst_tr [8];
   logic [NM-1:0] burst_gnt[8];
   logic [NM-1:0] oh;
   logic [NM-1:0] oh_nx;

   initial begin
      M_Haddr  = {32'h3000_0000, 32'h8000_0000, 32'h1000_0000};
      M_Hwdata = {32'h3000_00AA, 32'h1234_ABCD, 32'h1000_0003};
      M_Hwrite = 3'b011;
      Hrdata   = 32'hDEAD_BEEF;
      Hresp    = 2'b00;
      Hreadyout = 1'b1;

      // Reset held with everyone requesting.
      Hreset   = 1'b1;
      Hbusreq  = 3'b111;
      M_Htrans = {T_NS, T_NS, T_NS};
      tick();
      tick();
      check("rst_grant", 64'(Hgrant), 64'(3'b000));
      check("rst_owner", 64'(addr_owner), 64'(3'b000));
      check("rst_htrans", 64'(Htrans), 64'(T_IDLE));
      check("rst_haddr", 64'(Haddr), 64'h0);
      check("rst_hwdata", 64'(Hwdata), 64'h0);
      check("rst_hrdata_pass", 64'(M_Hrdata), 64'hDEAD_BEEF);
      check("rst_hreadyin", 64'(Hreadyin), 64'(1'b1));
      Hreset = 1'b0;
      tick();
      check("rst_first_grant", 64'(Hgrant), 64'(3'b001));

      // Single owner: master 1 NONSEQ write.
      do_reset();
      set_tr(1, T_NS);
      Hbusreq = 3'b010;
      tick();
      check("single_grant", 64'(Hgrant), 64'(3'b010));
      check("single_no_owner", 64'(Htrans), 64'(T_IDLE));
      tick();
      check("single_owner", 64'(addr_owner), 64'(3'b010));
      check("single_haddr", 64'(Haddr), 64'h8000_0000);
      check("single_htrans", 64'(Htrans), 64'(T_NS));
      check("single_hwrite", 64'(Hwrite), 64'(1'b1));
      check("single_wdata_pre", 64'(Hwdata), 64'h0);
      tick();
      check("single_wdata", 64'(Hwdata), 64'h1234_ABCD);
      set_tr(1, T_IDLE);
      Hbusreq = 3'b000;
      tick();
      check("single_release", 64'(Hgrant), 64'(3'b000));
      check("single_release_owner", 64'(addr_owner), 64'(3'b000));
      check("single_wdata_done", 64'(Hwdata), 64'h0);

      // Round robin: each master drops request after one transfer.
      do_reset();
      M_Htrans = {T_NS, T_NS, T_NS};
      Hbusreq  = 3'b111;
      tick();
      check("rr_grant0", 64'(Hgrant), 64'(3'b001));
      for (int k = 0; k < 3; k++) begin
         oh    = 3'(1 << k);
         oh_nx = 3'(1 << ((k + 1) % 3));
         tick();
         check("rr_owner", 64'(addr_owner), 64'(oh));
         tick();
         check("rr_hold_grant", 64'(Hgrant), 64'(oh));
         Hbusreq[k] = 1'b0;
         set_tr(k, T_IDLE);
         tick();
         check("rr_next_grant", 64'(Hgrant), 64'(oh_nx));
         Hbusreq[k] = 1'b1;
         set_tr(k, T_NS);
      end

      // Hold limit with NONSEQ stream: master 2 takes over after quota.
      do_reset();
      M_Htrans = {T_NS, T_IDLE, T_NS};
      Hbusreq  = 3'b101;
      tick();
      check("hold_grant0", 64'(Hgrant), 64'(3'b001));
      tick();
      check("hold_owner0", 64'(addr_owner), 64'(3'b001));
      for (int e = 0; e < 4; e++) begin
         tick();
         check("hold_keep", 64'(Hgrant), 64'(3'b001));
      end
      tick();
      check("hold_switch", 64'(Hgrant), 64'(3'b100));

      // Hold limit reached inside a burst: no split until it ends.
      burst_tr  = '{T_NS, T_NS, T_NS, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_IDLE};
      burst_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
      do_reset();
      M_Htrans = {T_NS, T_IDLE, T_IDLE};
      Hbusreq  = 3'b101;
      tick();
      tick();
      check("burst_owner0", 64'(addr_owner), 64'(3'b001));
      for (int j = 0; j < 8; j++) begin
         set_tr(0, burst_tr[j]);
         tick();
         check("burst_htrans", 64'(Htrans), 64'(burst_tr[j]));
         check("burst_grant", 64'(Hgrant), 64'(burst_gnt[j]));
      end

      // Wait states during handover 0 -> 1, with an ERROR response passed through.
      do_reset();
      M_Htrans = {T_IDLE, T_NS, T_NS};
      Hbusreq  = 3'b011;
      tick();
      tick();
      Hbusreq = 3'b010;
      tick();
      check("ws_grant1", 64'(Hgrant), 64'(3'b010));
      check("ws_owner_old", 64'(addr_owner), 64'(3'b001));
      check("ws_wdata0", 64'(Hwdata), 64'h1000_0003);
      set_tr(0, T_IDLE);
      Hreadyout = 1'b0;
      Hresp     = 2'b01;
      for (int w = 0; w < 3; w++) begin
         tick();
         check("ws_owner_frozen", 64'(addr_owner), 64'(3'b001));
         check("ws_wdata_frozen", 64'(Hwdata), 64'h1000_0003);
         check("ws_grant_frozen", 64'(Hgrant), 64'(3'b010));
      end
      check("ws_hreadyin", 64'(Hreadyin), 64'(1'b0));
      check("ws_mhready", 64'(M_Hready), 64'(1'b0));
      check("ws_hresp_err", 64'(M_Hresp), 64'(2'b01));
      Hreadyout = 1'b1;
      Hresp     = 2'b00;
      tick();
      check("ws_owner_new", 64'(addr_owner), 64'(3'b010));
      check("ws_haddr_new", 64'(Haddr), 64'h8000_0000);
      check("ws_wdata_done", 64'(Hwdata), 64'h0);
      tick();
      check("ws_wdata1", 64'(Hwdata), 64'h1234_ABCD);

      // Reset in the middle of master 1's burst; pointer returns to 0.
      set_tr(1, T_SEQ);
      Hreset  = 1'b1;
      Hbusreq = 3'b111;
      tick();
      check("mid_rst_grant", 64'(Hgrant), 64'(3'b000));
      check("mid_rst_htrans", 64'(Htrans), 64'(T_IDLE));
      check("mid_rst_owner", 64'(addr_owner), 64'(3'b000));
      check("mid_rst_wdata", 64'(Hwdata), 64'h0);
      Hreset = 1'b0;
      tick();
      check("mid_rst_ptr0", 64'(Hgrant), 64'(3'b001));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
